// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding,
// counter sizing and the full-adder cell the ripple chunk is built from.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter indexing 0..nchunk-1, never narrower than one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Combinational CHUNK-bit ripple adder built from the full-adder cell.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module ripple_chunk
    import add_sub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic cy;

    always_comb begin
        sum  = '0;
        cy   = cin;
        cmsb = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = cy;
            {cy, sum[i]} = full_add(a[i], b[i], cy);
        end
        cout = cy;
    end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract that processes CHUNK bits per clock
// through a single ripple_chunk, LSB slice first, with valid/ready handshakes.
module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("chunked_add_sub: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, sum_ext, s_nx;
    logic             carry, cout_r, ovf_r, zero_r;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_co, slice_cmsb;
    logic             accept, last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (cnt == CW'(NCHUNK - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_co),
        .cmsb (slice_cmsb)
    );

    // New slice enters at the top of the result register, so after NCHUNK
    // shifts slice 0 has reached the LSB.
    assign sum_ext = WIDTH'(slice_sum);
    assign s_nx    = (s_sh >> CHUNK) | (sum_ext << (WIDTH - CHUNK));

    // Operand shift registers carry no reset: they are only read in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b ^ {WIDTH{sub}};
        end else if (state == RUN) begin
            a_sh <= a_sh >> CHUNK;
            b_sh <= b_sh >> CHUNK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            s_sh   <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= sub;
        end else if (state == RUN) begin
            s_sh  <= s_nx;
            carry <= slice_co;
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) begin
                cout_r <= slice_co;
                ovf_r  <= slice_co ^ slice_cmsb;
                zero_r <= (s_nx == '0);
            end
        end
    end

    assign s    = s_sh;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule

// File: doc/chunked_add_sub.md
CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, else elaboration error.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned).
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  s == 0.

Function
REQ-016 FSM states IDLE, RUN, DONE; NCHUNK = WIDTH/CHUNK.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a, (b XOR {WIDTH{sub}}), carry=sub, chunk counter=0, go RUN.
REQ-018 RUN: in_ready=0; each cycle add one CHUNK slice (LSB first) of latched operands plus stored carry, store slice result, update carry, counter+1.
REQ-019 RUN -> DONE on the cycle processing slice NCHUNK-1; out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-020 DONE: out_valid=1, in_ready=0; s, cout, ovf, zero held stable until out_ready=1.
REQ-021 DONE with out_ready=1: go IDLE next edge; in_ready returns 1 the cycle after the handshake (no same-cycle back-to-back).
REQ-022 ovf = carry into MSB XOR carry out of MSB; zero computed from full s.
REQ-023 in_valid and operand changes outside IDLE SHALL be ignored; latched operands never change during RUN/DONE.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Throughput: one operation per NCHUNK+2 cycles when out_ready held high.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, s=0, cout=0, ovf=0, zero=0 (zero flag only valid with out_valid), counter=0.
REQ-027 Reset during RUN or DONE SHALL discard the operation; no out_valid is produced for it.

Structure
REQ-028 FSM state encoding and a NCHUNK-derived counter-width function SHALL live in shared package add_sub_pkg.
REQ-029 One sub-module, ripple_chunk: combinational CHUNK-bit ripple adder (a, b, cin -> sum, cout, msb carry-in), built from the existing full-adder cell.
REQ-030 Datapath: one ripple_chunk instance, operand shift registers, result shift register; no WIDTH-bit combinational adder.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-031 Add 0xFFFFFFFF+0x00000001 -> s=0x00000000, cout=1, zero=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-032 Sub 5-7 -> s=0xFFFFFFFE, cout=0, ovf=0, zero=0; sub 7-5 -> s=0x00000002, cout=1.
REQ-033 Add 0x7FFFFFFF+0x00000001 -> s=0x80000000, ovf=1, cout=0; sub 0x80000000-0x00000001 -> s=0x7FFFFFFF, ovf=1, cout=1.
REQ-034 Backpressure: out_ready low 3 cycles in DONE with in_valid pulsed -> outputs stable, in_ready=0, pulse ignored; result delivered once on out_ready=1.
REQ-035 rst_n asserted 2 cycles after accept -> out_valid stays 0, in_ready=1 after release, next operation 3+4 returns s=7 normally.
REQ-036 WIDTH=8, CHUNK=1: sub 0x80-0x01 -> s=0x7F, ovf=1, cout=1, latency 8 cycles.
